issue_scoreboard: RTL and testbench

Parametrised issue stage with a depth-configurable register/CPSR scoreboard. It sits between decode and execute. Each cycle it takes one decoded instruction with its use/def masks and condition result, and either issues it or inserts a bubble. Beyond the fixed two-stage tracker it replaces, it adds configurable tracking depth and register count, per-stage bypass masking, flush priority over stall, and a saturating hazard-stall counter.

---
 rtl/issue_scoreboard.sv | 116 +++++++++++
 tb/tb_issue_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard
// Purpose  : Decode->execute issue stage with a DEPTH-slot register/CPSR
//            scoreboard, per-slot bypass masking and a hazard-stall counter.
// Revision : 1.0  initial release
// ============================================================================
module issue_scoreboard #(
  parameter int              NREGS  = 16,
  parameter int              DEPTH  = 2,
  parameter logic [DEPTH-1:0] BYPASS = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             inbubble,
  input  logic [31:0]      insn,
  input  logic [31:0]      inpc,
  input  logic             cond_met,
  input  logic             use_cpsr,
  input  logic [NREGS-1:0] use_regs,
  input  logic             def_cpsr,
  input  logic [NREGS-1:0] def_regs,
  output logic             outstall,
  output logic             outbubble,
  output logic [31:0]      outpc,
  output logic [31:0]      outinsn,
  output logic             waiting,
  output logic [15:0]      stall_cycles
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  logic [DEPTH-1:0][NREGS-1:0] slot_regs_q, slot_regs_d;
  logic [DEPTH-1:0]            slot_cpsr_q, slot_cpsr_d;
  logic                        outbubble_q, outbubble_d;
  logic [31:0]                 outpc_q, outpc_d;
  logic [31:0]                 outinsn_q, outinsn_d;
  logic [15:0]                 stall_cycles_q, stall_cycles_d;

  logic [NREGS-1:0] blk_regs;
  logic             blk_cpsr;
  logic             hazard;
  logic             issuing;

  // Only slots whose results cannot be forwarded contribute to the blocking masks.
  always_comb begin
    blk_regs = '0;
    blk_cpsr = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!BYPASS[k]) begin
        blk_regs = blk_regs | slot_regs_q[k];
        blk_cpsr = blk_cpsr | slot_cpsr_q[k];
      end
    end
  end

  assign hazard   = (use_cpsr & blk_cpsr) | (|(use_regs & blk_regs));
  assign waiting  = hazard;
  assign outstall = (hazard & ~inbubble) | stall;
  assign issuing  = ~inbubble & ~hazard & cond_met;

  always_comb begin
    slot_regs_d    = slot_regs_q;
    slot_cpsr_d    = slot_cpsr_q;
    outbubble_d    = outbubble_q;
    outpc_d        = outpc_q;
    outinsn_d      = outinsn_q;
    stall_cycles_d = stall_cycles_q;

    if (flush) begin
      slot_regs_d = '0;
      slot_cpsr_d = '0;
      outbubble_d = 1'b1;
    end else if (!stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        slot_regs_d[k] = slot_regs_q[k-1];
        slot_cpsr_d[k] = slot_cpsr_q[k-1];
      end
      slot_regs_d[0] = issuing ? def_regs : '0;
      slot_cpsr_d[0] = issuing & def_cpsr;
      outbubble_d    = ~issuing;
      outpc_d        = inpc;
      outinsn_d      = insn;
      if (hazard && !inbubble && (stall_cycles_q != C_CNT_MAX)) begin
        stall_cycles_d = stall_cycles_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_regs_q    <= '0;
      slot_cpsr_q    <= '0;
      outbubble_q    <= 1'b1;
      outpc_q        <= '0;
      outinsn_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      slot_regs_q    <= slot_regs_d;
      slot_cpsr_q    <= slot_cpsr_d;
      outbubble_q    <= outbubble_d;
      outpc_q        <= outpc_d;
      outinsn_q      <= outinsn_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign outbubble    = outbubble_q;
  assign outpc        = outpc_q;
  assign outinsn      = outinsn_q;
  assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_scoreboard
// Purpose  : Self-checking bench; four scoreboard configurations share stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, inbubble, cond_met, use_cpsr, def_cpsr;
  logic [31:0] insn, inpc;
  logic [15:0] use_regs, def_regs;

  logic        w_ostall [4];
  logic        w_obub   [4];
  logic [31:0] w_opc    [4];
  logic [31:0] w_oinsn  [4];
  logic        w_wait   [4];
  logic [15:0] w_cnt    [4];

  int sel;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        bub;
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  issue_scoreboard #(.NREGS(16), .DEPTH(2), .BYPASS(2'b00)) u_d2_b00 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .inbubble(inbubble),
    .insn(insn), .inpc(inpc), .cond_met(cond_met), .use_cpsr(use_cpsr),
    .use_regs(use_regs), .def_cpsr(def_cpsr), .def_regs(def_regs),
    .outstall(w_ostall[0]), .outbubble(w_obub[0]), .outpc(w_opc[0]),
    .outinsn(w_oinsn[0]), .waiting(w_wait[0]), .stall_cycles(w_cnt[0]));

  issue_scoreboard #(.NREGS(16), .DEPTH(2), .BYPASS(2'b10)) u_d2_b10 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .inbubble(inbubble),
    .insn(insn), .inpc(inpc), .cond_met(cond_met), .use_cpsr(use_cpsr),
    .use_regs(use_regs), .def_cpsr(def_cpsr), .def_regs(def_regs),
    .outstall(w_ostall[1]), .outbubble(w_obub[1]), .outpc(w_opc[1]),
    .outinsn(w_oinsn[1]), .waiting(w_wait[1]), .stall_cycles(w_cnt[1]));

  issue_scoreboard #(.NREGS(16), .DEPTH(2), .BYPASS(2'b11)) u_d2_b11 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .inbubble(inbubble),
    .insn(insn), .inpc(inpc), .cond_met(cond_met), .use_cpsr(use_cpsr),
    .use_regs(use_regs), .def_cpsr(def_cpsr), .def_regs(def_regs),
    .outstall(w_ostall[2]), .outbubble(w_obub[2]), .outpc(w_opc[2]),
    .outinsn(w_oinsn[2]), .waiting(w_wait[2]), .stall_cycles(w_cnt[2]));

  issue_scoreboard #(.NREGS(16), .DEPTH(8), .BYPASS(8'h00)) u_d8_b00 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .inbubble(inbubble),
    .insn(insn), .inpc(inpc), .cond_met(cond_met), .use_cpsr(use_cpsr),
    .use_regs(use_regs), .def_cpsr(def_cpsr), .def_regs(def_regs),
    .outstall(w_ostall[3]), .outbubble(w_obub[3]), .outpc(w_opc[3]),
    .outinsn(w_oinsn[3]), .waiting(w_wait[3]), .stall_cycles(w_cnt[3]));

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return {16'hE1A0, pc[15:0]};
  endfunction

  task automatic drive(input logic bub, input logic [31:0] pc, input logic cm,
                       input logic uc, input logic [15:0] ur,
                       input logic dc, input logic [15:0] dr);
    inbubble = bub;  inpc = pc;  insn = insn_of(pc);  cond_met = cm;
    use_cpsr = uc;   use_regs = ur;  def_cpsr = dc;  def_regs = dr;
  endtask

  task automatic idle();
    drive(1'b1, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: check combinational outputs, push expected issue, pop it after the edge.
  task automatic tick(input logic e_stall, input logic e_wait,
                      input logic e_bub, input logic [31:0] e_pc);
    exp_t e;
    exp_t g;
    @(negedge clk);
    n_cmp++;
    if (w_ostall[sel] !== e_stall) begin
      n_bad++;
      $display("FAIL outstall[%0d] pc=%h: got %b expected %b", sel, inpc, w_ostall[sel], e_stall);
    end
    n_cmp++;
    if (w_wait[sel] !== e_wait) begin
      n_bad++;
      $display("FAIL waiting[%0d] pc=%h: got %b expected %b", sel, inpc, w_wait[sel], e_wait);
    end
    e.bub = e_bub;  e.pc = e_pc;  e.insn = insn_of(e_pc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    n_cmp++;
    if (w_obub[sel] !== g.bub || w_opc[sel] !== g.pc || w_oinsn[sel] !== g.insn) begin
      n_bad++;
      $display("FAIL issue[%0d]: got bub=%b pc=%h insn=%h expected bub=%b pc=%h insn=%h",
               sel, w_obub[sel], w_opc[sel], w_oinsn[sel], g.bub, g.pc, g.insn);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp_cnt);
    n_cmp++;
    if (w_cnt[sel] !== exp_cnt) begin
      n_bad++;
      $display("FAIL %s[%0d]: got stall_cycles=%h expected %h", tag, sel, w_cnt[sel], exp_cnt);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (w_obub[s] !== 1'b1 || w_opc[s] !== 32'h0 || w_oinsn[s] !== 32'h0 ||
          w_cnt[s] !== 16'h0 || w_wait[s] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset[%0d]: got bub=%b pc=%h insn=%h cnt=%h wait=%b expected 1/0/0/0/0",
                 s, w_obub[s], w_opc[s], w_oinsn[s], w_cnt[s], w_wait[s]);
      end
    end
    do_reset();
  endtask

  task automatic test_raw(input int s, input int nst);
    sel = s;
    do_reset();
    drive(1'b0, 32'h100, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0008);
    tick(1'b0, 1'b0, 1'b0, 32'h100);
    drive(1'b0, 32'h104, 1'b1, 1'b0, 16'h0008, 1'b0, 16'h0);
    for (int i = 0; i <= nst; i++) begin
      tick(i < nst, i < nst, i < nst, 32'h104);
    end
    idle();
    check_cnt("raw_count", 16'(nst));
  endtask

  task automatic test_cpsr_condfail();
    sel = 0;
    do_reset();
    drive(1'b0, 32'h200, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h200);
    drive(1'b0, 32'h204, 1'b1, 1'b1, 16'h0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h204);
    idle();
    check_cnt("cpsr_count", 16'h0);
  endtask

  task automatic test_flush_vs_stall();
    sel = 0;
    do_reset();
    drive(1'b0, 32'h300, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0020);
    tick(1'b0, 1'b0, 1'b0, 32'h300);
    idle();
    flush = 1'b1;
    stall = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 32'h300);
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'h304, 1'b1, 1'b0, 16'h0020, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h304);
    idle();
    check_cnt("flush_count", 16'h0);
  endtask

  task automatic test_stall_hold();
    sel = 0;
    do_reset();
    drive(1'b0, 32'h500, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0080);
    tick(1'b0, 1'b0, 1'b0, 32'h500);
    drive(1'b0, 32'h504, 1'b1, 1'b0, 16'h0080, 1'b0, 16'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'h500);
    stall = 1'b0;
    tick(1'b1, 1'b1, 1'b1, 32'h504);
    tick(1'b1, 1'b1, 1'b1, 32'h504);
    tick(1'b0, 1'b0, 1'b0, 32'h504);
    idle();
    check_cnt("stall_hold_count", 16'h2);
  endtask

  task automatic test_async_reset();
    sel = 0;
    do_reset();
    drive(1'b0, 32'h600, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0004);
    tick(1'b0, 1'b0, 1'b0, 32'h600);
    drive(1'b0, 32'h604, 1'b1, 1'b0, 16'h0004, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h604);
    check_cnt("pre_reset_count", 16'h1);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (w_obub[0] !== 1'b1 || w_opc[0] !== 32'h0 || w_oinsn[0] !== 32'h0 ||
        w_cnt[0] !== 16'h0 || w_wait[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got bub=%b pc=%h insn=%h cnt=%h wait=%b expected 1/0/0/0/0",
               w_obub[0], w_opc[0], w_oinsn[0], w_cnt[0], w_wait[0]);
    end
    #1 rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 32'h604);
    idle();
  endtask

  task automatic test_saturation();
    int n;
    sel = 3;
    do_reset();
    drive(1'b0, 32'h700, 1'b1, 1'b0, 16'h0002, 1'b0, 16'h0002);
    n = 0;
    while (w_cnt[3] !== 16'hFFFE && n < 80000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_cnt("sat_preload", 16'hFFFE);
    repeat (30) @(posedge clk);
    #1;
    check_cnt("sat_reach", 16'hFFFF);
    repeat (20) @(posedge clk);
    #1;
    check_cnt("sat_hold", 16'hFFFF);
    idle();
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_raw(0, 2);
    test_raw(1, 1);
    test_raw(2, 0);
    test_raw(3, 8);
    test_cpsr_condfail();
    test_flush_vs_stall();
    test_stall_hold();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
